// File: rtl/prm_scan_pkg.sv
// Shared types and default widths for the edge-scan controller slice.
package prm_scan_pkg;
   localparam int IDX_W_DEF  = 15;
   localparam int WORD_W_DEF = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_FIN} scan_st_e;
endpackage

// File: rtl/prm_mask_packer.sv
// Packs registered checker bits LSB-first into WORD_W words with a valid/ready output register.
module prm_mask_packer #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_vld,
   input  logic              in_bit,
   input  logic              in_last,
   output logic [WORD_W-1:0] out_word,
   output logic              out_vld,
   output logic              out_last,
   input  logic              out_rdy,
   output logic [CNT_W-1:0]  cnt
);
   logic [WORD_W-1:0] acc, acc_n;
   logic [CNT_W-1:0]  cnt_n;
   logic              acc_last, last_n;
   logic              out_free, flush;

   // Accumulator after absorbing this cycle's sample; a full or final word
   // may still sit here while the output register is blocked.
   always_comb begin
      acc_n  = acc;
      cnt_n  = cnt;
      last_n = acc_last;
      if (in_vld) begin
         acc_n  = acc | (WORD_W'(in_bit) << cnt);
         cnt_n  = cnt + CNT_W'(1);
         last_n = acc_last | in_last;
      end
   end

   assign out_free = ~out_vld | out_rdy;
   assign flush    = (cnt_n == CNT_W'(WORD_W)) | last_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         acc_last <= 1'b0;
         out_word <= '0;
         out_vld  <= 1'b0;
         out_last <= 1'b0;
      end else if (clr) begin
         acc      <= '0;
         cnt      <= '0;
         acc_last <= 1'b0;
         out_vld  <= 1'b0;
         out_last <= 1'b0;
      end else if (flush && out_free) begin
         out_word <= acc_n;
         out_vld  <= 1'b1;
         out_last <= last_n;
         acc      <= '0;
         cnt      <= '0;
         acc_last <= 1'b0;
      end else begin
         acc      <= acc_n;
         cnt      <= cnt_n;
         acc_last <= last_n;
         if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks an inclusive index range through an external 1-cycle edge checker and packs the mask bits into words.
module prm_edge_scan_ctrl
   import prm_scan_pkg::*;
#(
   parameter int IDX_W  = IDX_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  first_idx,
   input  logic [IDX_W-1:0]  last_idx,
   input  logic              abort,
   output logic [IDX_W-1:0]  chk_idx,
   input  logic              chk_mask,
   output logic [WORD_W-1:0] out_word,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [IDX_W:0]    hit_cnt
);
   localparam int CNT_W = $clog2(WORD_W + 1);

   scan_st_e         state, state_nxt;
   logic [IDX_W:0]   idx, last_q;
   logic             vld_pipe, smp_bit, smp_last;
   logic             accept, issue, is_last, empty, stall, pk_clr;
   logic [CNT_W-1:0] pk_cnt;

   assign accept  = (state == ST_IDLE) & start & ~abort;
   assign pk_clr  = (state != ST_IDLE) & abort;
   // Extra index bit lets a range ending at the top index finish without wrapping.
   assign empty   = idx > last_q;
   assign is_last = idx == last_q;
   assign stall   = out_vld & ~out_rdy & ((int'(pk_cnt) + int'(vld_pipe)) >= WORD_W);
   assign issue   = (state == ST_SCAN) & ~empty & ~stall & ~abort;
   assign chk_idx = idx[IDX_W-1:0];

   always_comb begin
      state_nxt = state;
      busy      = state != ST_IDLE;
      done      = state == ST_FIN;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SCAN;
         ST_SCAN:  if (empty) state_nxt = ST_FIN;
                   else if (issue && is_last) state_nxt = ST_DRAIN;
         ST_DRAIN: if (out_vld && out_rdy && out_last) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (pk_clr) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         last_q   <= '0;
         vld_pipe <= 1'b0;
         smp_bit  <= 1'b0;
         smp_last <= 1'b0;
         hit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         vld_pipe <= issue;
         smp_bit  <= chk_mask;
         smp_last <= issue & is_last;
         if (accept) begin
            idx    <= {1'b0, first_idx};
            last_q <= {1'b0, last_idx};
         end else if (issue) begin
            idx <= idx + (IDX_W+1)'(1);
         end
         if (accept)
            hit_cnt <= '0;
         else if (vld_pipe && smp_bit && !pk_clr)
            hit_cnt <= hit_cnt + (IDX_W+1)'(1);
      end
   end

   prm_mask_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (pk_clr),
      .in_vld   (vld_pipe),
      .in_bit   (smp_bit),
      .in_last  (smp_last),
      .out_word (out_word),
      .out_vld  (out_vld),
      .out_last (out_last),
      .out_rdy  (out_rdy),
      .cnt      (pk_cnt)
   );
endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Scoreboard bench: directed scans push expected words, a negedge monitor checks each accepted word.
module tb_prm_edge_scan_ctrl;
   localparam int IDX_W  = 15;
   localparam int WORD_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0, abort = 1'b0, out_rdy = 1'b1;
   logic [IDX_W-1:0]  first_idx = '0, last_idx = '0, chk_idx;
   logic              chk_mask;
   logic [WORD_W-1:0] out_word;
   logic              out_vld, out_last, busy, done;
   logic [IDX_W:0]    hit_cnt;

   int mode = 0;
   int checks = 0, errors = 0, done_cnt = 0;
   logic [WORD_W:0] sb[$];

   always #5 clk = ~clk;

   // Checker model: 0 -> odd indices, 1 -> all edges blocked, 2 -> multiples of 3
   always_comb begin
      chk_mask = 1'b0;
      case (mode)
         0: chk_mask = chk_idx[0];
         1: chk_mask = 1'b1;
         default: chk_mask = (int'(chk_idx) % 3) == 0;
      endcase
   end

   prm_edge_scan_ctrl #(.IDX_W(IDX_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
      .abort(abort), .chk_idx(chk_idx), .chk_mask(chk_mask), .out_word(out_word),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last), .busy(busy),
      .done(done), .hit_cnt(hit_cnt)
   );

   // Monitor: every accepted word must match the head of the scoreboard
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (out_vld && out_rdy) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h last=%0b, none expected", out_word, out_last);
         end else begin
            logic [WORD_W:0] e;
            e = sb.pop_front();
            if ({out_last, out_word} !== e) begin
               errors++;
               $display("FAIL word: got last=%0b %h, expected last=%0b %h",
                        out_last, out_word, e[WORD_W], e[WORD_W-1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic last, input logic [WORD_W-1:0] w);
      sb.push_back({last, w});
   endtask

   task automatic start_scan(input int f, input int l);
      first_idx = IDX_W'(f);
      last_idx  = IDX_W'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_out_vld"}, out_vld, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_out_word"}, out_word, 0);
      chk({tag, "_chk_idx"}, chk_idx, 0);
      chk({tag, "_hit_cnt"}, hit_cnt, 0);
   endtask

   // Runs one scan to completion; optional ready-low window and latency bound
   task automatic run_scan(input string name, input int f, input int l, input int m,
                           input int off_at, input int off_len, input int exp_hit,
                           input int max_cyc);
      int d0, cyc;
      logic prev_blk;
      logic [WORD_W:0] held;
      bit got;
      mode = m;
      d0 = done_cnt;
      start_scan(f, l);
      got = 0;
      prev_blk = 1'b0;
      held = '0;
      cyc = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i == off_at) out_rdy = 1'b0;
         if (i == off_at + off_len) out_rdy = 1'b1;
         prev_blk = out_vld & ~out_rdy;
         held = {out_last, out_word};
         tick();
         cyc++;
         if (prev_blk) chk({name, "_stall_hold"}, {out_last, out_word}, held);
         if (done) begin got = 1; break; end
      end
      out_rdy = 1'b1;
      chk({name, "_done_seen"}, got, 1);
      if (max_cyc > 0) begin
         checks++;
         if (cyc > max_cyc) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected <= %0d", name, cyc, max_cyc);
         end
      end
      chk({name, "_hit_cnt"}, hit_cnt, exp_hit);
      tick();
      chk({name, "_done_once"}, done_cnt - d0, 1);
      chk({name, "_idle"}, busy, 0);
      chk({name, "_sb_empty"}, sb.size(), 0);
      tick();
      chk({name, "_hit_hold"}, hit_cnt, exp_hit);
   endtask

   initial begin
      int d0;
      #2;
      check_reset_vals("reset");
      tick();
      rst = 1'b0;
      tick();

      // odd-index mask, one full word
      push(1'b1, 32'hAAAAAAAA);
      run_scan("odd32", 0, 31, 0, -1, 0, 16, 35);

      // all-ones, offset start, partial final word
      push(1'b0, 32'hFFFFFFFF);
      push(1'b1, 32'h0000000F);
      run_scan("ones36", 5, 40, 1, -1, 0, 36, 0);

      // multiples of 3 with ready dropped for 20 cycles mid-scan
      push(1'b0, 32'h49249249);
      push(1'b0, 32'h92492492);
      push(1'b1, 32'h24924924);
      run_scan("stall96", 0, 95, 2, 60, 20, 32, 0);

      // long stall: packer fills behind a blocked word and issue must pause
      push(1'b0, 32'h49249249);
      push(1'b0, 32'h92492492);
      push(1'b0, 32'h24924924);
      push(1'b1, 32'h49249249);
      run_scan("stall128", 0, 127, 2, 40, 70, 43, 0);

      // top of index space
      push(1'b1, 32'h0000FFFF);
      run_scan("top", 32'h7FF0, 32'h7FFF, 1, -1, 0, 16, 0);

      // empty range: done exactly two cycles after start
      mode = 1;
      d0 = done_cnt;
      start_scan(10, 3);
      chk("empty_c1_done", done, 0);
      chk("empty_c1_busy", busy, 1);
      tick();
      chk("empty_c2_done", done, 1);
      tick();
      chk("empty_idle", busy, 0);
      chk("empty_done_once", done_cnt - d0, 1);
      chk("empty_hit", hit_cnt, 0);

      // abort at cycle 7 of a 0..63 scan
      d0 = done_cnt;
      start_scan(0, 63);
      repeat (6) tick();
      chk("abort_pre_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_out_vld", out_vld, 0);
      repeat (40) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_still_idle", busy, 0);

      // abort wins over start in the same cycle
      abort = 1'b1;
      start_scan(0, 7);
      abort = 1'b0;
      chk("abort_beats_start", busy, 0);
      tick();

      // reset mid-scan, then a normal scan
      mode = 2;
      d0 = done_cnt;
      start_scan(0, 95);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      check_reset_vals("midrst");
      rst = 1'b0;
      repeat (5) tick();
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle", busy, 0);
      push(1'b1, 32'hAAAAAAAA);
      run_scan("post_rst", 0, 31, 0, -1, 0, 16, 35);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prm_edge_scan_ctrl.md
PRM_EDGE_SCAN_CTRL -- requirements
Module: prm_edge_scan_ctrl

Interface
REQ-001 Parameter IDX_W, default 15, width of edge-check index (one bit per checker input A..O, A = bit 0).
REQ-002 Parameter WORD_W, default 32, width of packed mask output word.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin scan when in IDLE; ignored otherwise.
REQ-006 first_idx  input  IDX_W  first index of inclusive scan range, sampled on accepted start.
REQ-007 last_idx  input  IDX_W  last index of inclusive scan range, sampled on accepted start.
REQ-008 abort  input  1  terminate scan, return to IDLE.
REQ-009 chk_idx  output  IDX_W  index driven to the combinational obstacle checker.
REQ-010 chk_mask  input  1  checker edge_mask result for chk_idx, same cycle.
REQ-011 out_word  output  WORD_W  packed mask word.
REQ-012 out_vld / out_rdy  output / input  1 each  valid/ready handshake for out_word.
REQ-013 out_last  output  1  marks final word of scan, qualified by out_vld.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when final word is accepted.
REQ-016 hit_cnt  output  IDX_W+1  number of indices with chk_mask=1 in current/last scan.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN, FIN; IDLE->SCAN on start; SCAN->DRAIN after last index sampled; DRAIN->FIN when final word handshakes; FIN->IDLE next cycle with done=1 in FIN.
REQ-018 Index counter SHALL be IDX_W+1 bits so last_idx = 2^IDX_W-1 terminates without wrap-around.
REQ-019 chk_mask SHALL be registered one cycle (fixed checker latency 1); valid delay bit tracks in-flight sample.
REQ-020 In SCAN one index issued per cycle unless stalled; stall when out_vld=1, out_rdy=0 and packer count plus in-flight samples >= WORD_W.
REQ-021 Bit k of word n SHALL equal mask of index first_idx + n*WORD_W + k.
REQ-022 Word emitted when WORD_W bits collected or final sample packed; unused upper bits of partial last word SHALL be 0.
REQ-023 out_word/out_last SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-024 Packer SHALL accept a new sample in the same cycle the output word handshakes (no bubble at full throughput).
REQ-025 first_idx > last_idx: empty scan, no words emitted, SCAN->FIN directly, done pulses 2 cycles after start.
REQ-026 hit_cnt cleared on accepted start, incremented per registered chk_mask=1, held after FIN.
REQ-027 abort in any non-IDLE state: next cycle IDLE, out_vld=0, packer and in-flight cleared, no done pulse; abort beats start in same cycle.
REQ-028 Throughput with out_rdy=1: N indices complete in N+ceil(N/WORD_W)-dependent ≤ N+3 cycles.

Reset
REQ-029 On rst: state IDLE, busy=0, done=0, out_vld=0, out_last=0, out_word=0, chk_idx=0, hit_cnt=0, packer count 0.
REQ-030 rst asserted mid-scan SHALL discard all partial results; no done pulse after release.

Structure
REQ-031 Package prm_scan_pkg holds state enum, IDX_W and WORD_W defaults.
REQ-032 Sub-module prm_mask_packer (shift-in bit, count, output word register, valid/ready) instantiated once.
REQ-033 Checker instantiated outside this block; no combinational path from chk_mask to out_*.

Verification
REQ-034 first=0, last=31, checker mask = idx[0], out_rdy=1 -> one word 0xAAAAAAAA, out_last=1, hit_cnt=16, done once.
REQ-035 first=5, last=40, mask=1 always -> words 0xFFFFFFFF then 0x0000000F with out_last, hit_cnt=36.
REQ-036 first=0, last=95, out_rdy low 20 cycles mid-scan -> 3 words, no lost/duplicated bit, out_word stable during stall.
REQ-037 first=0x7FF0, last=0x7FFF -> one word with 16 valid bits, upper 16 zero, scan terminates, no wrap.
REQ-038 first=10, last=3 -> no out_vld, done 2 cycles after start; abort at cycle 7 of 0..63 scan -> IDLE, no done.
REQ-039 rst pulsed mid-scan -> all outputs at REQ-029 values; subsequent start completes normally.
